// File: rtl/blinds_ctrl_if.sv
// blinds_ctrl_if -- bundles the sensor/button/enable inputs and the per-channel
// motor outputs of blinds_ctrl.
//   intensity  N*IW  channel c at [c*IW +: IW]
//   button     N     per-channel close override
//   enable     1     global motor enable
//   pos        2*N   channel c position at [2c +: 2]
//   moving     N     channel stepping and enabled
//   dir        N     1 = closing, 0 = opening
//   arrive     N     one-cycle pulse on reaching target
// master drives the inputs (sensor side), slave is the controller.
interface blinds_ctrl_if #(
    parameter int N  = 2,
    parameter int IW = 4
);
    logic [N*IW-1:0] intensity;
    logic [N-1:0]    button;
    logic            enable;
    logic [2*N-1:0]  pos;
    logic [N-1:0]    moving;
    logic [N-1:0]    dir;
    logic [N-1:0]    arrive;

    modport master (output intensity, button, enable,
                    input  pos, moving, dir, arrive);
    modport slave  (input  intensity, button, enable,
                    output pos, moving, dir, arrive);
endinterface

// File: rtl/blinds_ctrl.sv
// blinds_ctrl -- N-channel automatic blinds controller.
// Each channel bands its light sample into a level 0..3, qualifies the band
// for STABLE cycles, lets a button force level 3, and steps the blind one
// level per STEP_CYCLES dwell toward that target.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  blinds_ctrl_if.slave (intensity/button/enable in, pos/moving/dir/arrive out)

// One channel: band mapping, qualification and motor FSM.
module blinds_chan #(
    parameter int IW          = 4,
    parameter int T_HI        = 7,
    parameter int T_MID       = 5,
    parameter int T_LO        = 3,
    parameter int STABLE      = 4,
    parameter int STEP_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] intensity_i,
    input  logic          button_i,
    input  logic          enable_i,
    output logic [1:0]    pos_o,
    output logic          moving_o,
    output logic          dir_o,
    output logic          arrive_o
);
    localparam int CNTW = $clog2(STABLE + 1);
    localparam int SW   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [IW-1:0]   TH_HI     = IW'(T_HI);
    localparam logic [IW-1:0]   TH_MID    = IW'(T_MID);
    localparam logic [IW-1:0]   TH_LO     = IW'(T_LO);
    localparam logic [CNTW-1:0] STABLE_C  = CNTW'(STABLE);
    localparam logic [SW-1:0]   STEP_LAST = SW'(STEP_CYCLES - 1);

    typedef enum logic {IDLE, MOVE} state_t;

    logic [1:0]      band;
    logic [1:0]      cand_q, cand_d, tgt_auto_q, tgt_auto_d, tgt;
    logic [CNTW-1:0] cnt_q, cnt_d;
    state_t          state_q, state_d;
    logic [1:0]      pos_q, pos_d, pos_step;
    logic [SW-1:0]   stp_q, stp_d;
    logic            dir_q, dir_d, arrive_q, arrive_d;

    always_comb begin
        if (intensity_i >= TH_HI)       band = 2'd0;
        else if (intensity_i >= TH_MID) band = 2'd1;
        else if (intensity_i >= TH_LO)  band = 2'd2;
        else                            band = 2'd3;
    end

    // Target latches off the next count so a band held STABLE consecutive
    // samples is adopted on the edge of its STABLE-th sample.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (band != cand_q) begin
            cand_d = band;
            cnt_d  = CNTW'(1);
        end else if (cnt_q != STABLE_C) begin
            cnt_d  = cnt_q + CNTW'(1);
        end
        tgt_auto_d = (cnt_d == STABLE_C) ? cand_d : tgt_auto_q;
    end

    assign tgt      = button_i ? 2'd3 : tgt_auto_q;
    assign pos_step = dir_q ? pos_q + 2'd1 : pos_q - 2'd1;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        stp_d    = stp_q;
        dir_d    = dir_q;
        arrive_d = 1'b0;
        if (enable_i) begin
            case (state_q)
                IDLE: if (tgt != pos_q) begin
                    state_d = MOVE;
                    stp_d   = '0;
                    dir_d   = (tgt > pos_q);
                end
                MOVE: begin
                    if (tgt == pos_q) begin
                        // target moved back onto us: stop without arriving
                        state_d = IDLE;
                        stp_d   = '0;
                    end else if ((tgt > pos_q) != dir_q) begin
                        dir_d = ~dir_q;
                        stp_d = '0;
                    end else if (stp_q == STEP_LAST) begin
                        pos_d = pos_step;
                        stp_d = '0;
                        if (pos_step == tgt) begin
                            state_d  = IDLE;
                            arrive_d = 1'b1;
                        end
                    end else begin
                        stp_d = stp_q + SW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q     <= 2'd0;
            cnt_q      <= STABLE_C;
            tgt_auto_q <= 2'd0;
            state_q    <= IDLE;
            pos_q      <= 2'd0;
            stp_q      <= '0;
            dir_q      <= 1'b0;
            arrive_q   <= 1'b0;
        end else begin
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            tgt_auto_q <= tgt_auto_d;
            state_q    <= state_d;
            pos_q      <= pos_d;
            stp_q      <= stp_d;
            dir_q      <= dir_d;
            arrive_q   <= arrive_d;
        end
    end

    assign pos_o    = pos_q;
    assign dir_o    = dir_q;
    assign arrive_o = arrive_q;
    assign moving_o = (state_q == MOVE) && enable_i;
endmodule

module blinds_ctrl #(
    parameter int N           = 2,
    parameter int IW          = 4,
    parameter int T_HI        = 7,
    parameter int T_MID       = 5,
    parameter int T_LO        = 3,
    parameter int STABLE      = 4,
    parameter int STEP_CYCLES = 4
) (
    input logic          clk,
    input logic          rst,
    blinds_ctrl_if.slave bus
);
    for (genvar c = 0; c < N; c++) begin : g_chan
        blinds_chan #(
            .IW(IW), .T_HI(T_HI), .T_MID(T_MID), .T_LO(T_LO),
            .STABLE(STABLE), .STEP_CYCLES(STEP_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .intensity_i(bus.intensity[c*IW +: IW]),
            .button_i   (bus.button[c]),
            .enable_i   (bus.enable),
            .pos_o      (bus.pos[2*c +: 2]),
            .moving_o   (bus.moving[c]),
            .dir_o      (bus.dir[c]),
            .arrive_o   (bus.arrive[c])
        );
    end
endmodule
